// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the scoring-console command path: the 4-bit command
// codes (also used by the scoring FSM), the ASCII characters that make up the
// command set, and the decoder FSM state encoding.
// -----------------------------------------------------------------------------
package cmd_pkg;

  // Command codes delivered on cmd_code
  localparam logic [3:0] CMD_RESET = 4'd0;  // "r"
  localparam logic [3:0] CMD_T1    = 4'd1;  // "t1"
  localparam logic [3:0] CMD_T2    = 4'd2;  // "t2"
  localparam logic [3:0] CMD_GO    = 4'd3;  // "g"
  localparam logic [3:0] CMD_S1    = 4'd4;  // "s1"
  localparam logic [3:0] CMD_S2    = 4'd5;  // "s2"
  localparam logic [3:0] CMD_S3    = 4'd6;  // "s3"
  localparam logic [3:0] CMD_P1    = 4'd7;  // "1"
  localparam logic [3:0] CMD_P2    = 4'd8;  // "2"
  localparam logic [3:0] CMD_NONE  = 4'hF;  // no / invalid command

  // ASCII characters used by the decoder
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_A_UP   = 8'h41;
  localparam logic [7:0] ASCII_Z_UP   = 8'h5A;
  localparam logic [7:0] ASCII_LC_BIT = 8'h20;  // upper -> lower case offset
  localparam logic [7:0] ASCII_R      = 8'h72;
  localparam logic [7:0] ASCII_T      = 8'h74;
  localparam logic [7:0] ASCII_G      = 8'h67;
  localparam logic [7:0] ASCII_S      = 8'h73;
  localparam logic [7:0] ASCII_1      = 8'h31;
  localparam logic [7:0] ASCII_2      = 8'h32;
  localparam logic [7:0] ASCII_3      = 8'h33;

  // Decoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_match.sv
// -----------------------------------------------------------------------------
// cmd_match
// Purely combinational whole-line matcher. Compares the buffered line (first
// len characters of line) against the fixed command table.
//   line : buffered characters, index 0 is the first received
//   len  : number of valid characters in line
//   code : table code on a hit, CMD_NONE otherwise
//   hit  : line is a recognised command
// -----------------------------------------------------------------------------
module cmd_match
  import cmd_pkg::*;
#(
  parameter int DATA_W  = 7,
  parameter int MAX_LEN = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0][DATA_W-1:0] line,
  input  logic [LEN_W-1:0]               len,
  output logic [3:0]                     code,
  output logic                           hit
);

  // Characters widened to 32 bits so the table compares independently of
  // DATA_W; a second character only exists when the buffer can hold one.
  logic [31:0] c0;
  logic [31:0] c1;

  assign c0 = 32'(line[0]);

  generate
    if (MAX_LEN > 1) begin : g_two_char
      assign c1 = 32'(line[1]);
    end else begin : g_one_char
      assign c1 = '0;
    end
  endgenerate

  always_comb begin
    code = CMD_NONE;
    if (32'(len) == 32'd1) begin
      case (c0)
        32'(ASCII_R): code = CMD_RESET;
        32'(ASCII_G): code = CMD_GO;
        32'(ASCII_1): code = CMD_P1;
        32'(ASCII_2): code = CMD_P2;
        default:      code = CMD_NONE;
      endcase
    end else if (32'(len) == 32'd2) begin
      case ({c0, c1})
        {32'(ASCII_T), 32'(ASCII_1)}: code = CMD_T1;
        {32'(ASCII_T), 32'(ASCII_2)}: code = CMD_T2;
        {32'(ASCII_S), 32'(ASCII_1)}: code = CMD_S1;
        {32'(ASCII_S), 32'(ASCII_2)}: code = CMD_S2;
        {32'(ASCII_S), 32'(ASCII_3)}: code = CMD_S3;
        default:                      code = CMD_NONE;
      endcase
    end
  end

  assign hit = (code != CMD_NONE);

endmodule

// File: rtl/cmd_decoder.sv
// -----------------------------------------------------------------------------
// cmd_decoder
// Collects characters from the UART receiver into a line buffer until the
// terminator arrives, then matches the whole line against the command table
// and reports the result to the scoring FSM.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   datain     : received character, valid while data_ready is high
//   data_ready : receiver byte-ready level (one character per rising edge)
//   cmd_code   : last decoded code, held until the next line completes
//   cmd_valid  : one-cycle strobe, cmd_code holds a recognised command
//   cmd_err    : one-cycle strobe, line was unknown, overflowed or empty
//   busy       : a partial line is buffered (COLLECT or DISCARD)
// -----------------------------------------------------------------------------
module cmd_decoder
  import cmd_pkg::*;
#(
  parameter int                DATA_W      = 7,
  parameter int                MAX_LEN     = 2,
  parameter logic [DATA_W-1:0] TERM        = DATA_W'(8'h0D),
  parameter int                TIMEOUT_CYC = 50_000_000,
  parameter int                CASE_FOLD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              data_ready,
  output logic [3:0]        cmd_code,
  output logic              cmd_valid,
  output logic              cmd_err,
  output logic              busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                         state_q, state_d;
  logic [MAX_LEN-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
  logic                           data_ready_q;
  logic [3:0]                     cmd_code_q, cmd_code_d;
  logic                           cmd_valid_q, cmd_valid_d;
  logic                           cmd_err_q, cmd_err_d;
  logic                           busy_q, busy_d;

  logic              accept;
  logic              is_term;
  logic              timeout_hit;
  logic [DATA_W-1:0] char_in;
  logic [3:0]        match_code;
  logic              match_hit;

  // A character is taken only on the rising edge of data_ready.
  assign accept = data_ready & ~data_ready_q;

  // Optional upper-to-lower case folding ahead of storage and compare.
  always_comb begin
    char_in = datain;
    if ((CASE_FOLD != 0) &&
        (32'(datain) >= 32'(ASCII_A_UP)) && (32'(datain) <= 32'(ASCII_Z_UP))) begin
      char_in = datain | DATA_W'(ASCII_LC_BIT);
    end
  end

  assign is_term     = (char_in == TERM);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);

  cmd_match #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .line (buf_q),
    .len  (len_q),
    .code (match_code),
    .hit  (match_hit)
  );

  // Next-state logic. The strobes are registered: they are decided on the
  // terminator's accept cycle and therefore appear during the EMIT cycle.
  // Being in DISCARD when the terminator arrives is the overflow condition.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    to_cnt_d    = '0;
    cmd_code_d  = cmd_code_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_EMIT: begin
        // EMIT clears the line, then behaves exactly like IDLE so an accept
        // edge arriving here is not lost.
        if (state_q == ST_EMIT) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          len_d   = '0;
        end
        if (accept) begin
          if (is_term) begin
            // Empty line
            state_d    = ST_EMIT;
            cmd_code_d = CMD_NONE;
            cmd_err_d  = 1'b1;
          end else begin
            state_d  = ST_COLLECT;
            buf_d    = '0;
            buf_d[0] = char_in;
            len_d    = LEN_W'(1);
          end
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          if (is_term) begin
            state_d = ST_EMIT;
            if (match_hit) begin
              cmd_code_d  = match_code;
              cmd_valid_d = 1'b1;
            end else begin
              cmd_code_d = CMD_NONE;
              cmd_err_d  = 1'b1;
            end
          end else if (len_q == LEN_MAX) begin
            state_d = ST_DISCARD;
          end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (32'(len_q) == i) buf_d[i] = char_in;
            end
            len_d = len_q + LEN_W'(1);
          end
        end else if (timeout_hit) begin
          // Silent drop of a stale partial line
          state_d = ST_IDLE;
          buf_d   = '0;
          len_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_DISCARD: begin
        if (accept) begin
          if (is_term) begin
            state_d    = ST_EMIT;
            cmd_code_d = CMD_NONE;
            cmd_err_d  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          len_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        buf_d   = '0;
        len_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_DISCARD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      len_q        <= '0;
      to_cnt_q     <= '0;
      data_ready_q <= 1'b0;
      cmd_code_q   <= CMD_NONE;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      to_cnt_q     <= to_cnt_d;
      data_ready_q <= data_ready;
      cmd_code_q   <= cmd_code_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_code  = cmd_code_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_cmd_decoder
// Directed bench for cmd_decoder. Two instances share the stimulus: dut0 with
// CASE_FOLD=0 and dut1 with CASE_FOLD=1, both MAX_LEN=2 and TIMEOUT_CYC=20.
// -----------------------------------------------------------------------------
module tb_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] datain;
  logic       data_ready;

  logic [3:0] code0, code1;
  logic       valid0, valid1, err0, err1, busy0, busy1;

  int n_vec = 0;
  int n_bad = 0;
  int nv0 = 0, ne0 = 0;
  int sv, se;

  always #5 clk = ~clk;

  cmd_decoder #(
    .DATA_W(7), .MAX_LEN(2), .TERM(7'h0D), .TIMEOUT_CYC(20), .CASE_FOLD(0)
  ) dut0 (
    .clk(clk), .reset(reset), .datain(datain), .data_ready(data_ready),
    .cmd_code(code0), .cmd_valid(valid0), .cmd_err(err0), .busy(busy0)
  );

  cmd_decoder #(
    .DATA_W(7), .MAX_LEN(2), .TERM(7'h0D), .TIMEOUT_CYC(20), .CASE_FOLD(1)
  ) dut1 (
    .clk(clk), .reset(reset), .datain(datain), .data_ready(data_ready),
    .cmd_code(code1), .cmd_valid(valid1), .cmd_err(err1), .busy(busy1)
  );

  // Strobe counters for dut0
  always @(negedge clk) begin
    if (!reset) begin
      if (valid0) nv0++;
      if (err0) ne0++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One character as a 3-cycle data_ready pulse followed by one low cycle.
  task automatic send_char(input logic [6:0] c);
    @(negedge clk);
    datain     = c;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  // Terminator with strobe checks one cycle after acceptance and one cycle
  // later (strobe must have dropped). Expected code 4'hF means cmd_err.
  task automatic send_term(input string tag, input logic [3:0] exp0, input logic [3:0] exp1);
    @(negedge clk);
    datain     = 7'h0D;
    data_ready = 1'b1;
    @(negedge clk);
    check({tag, ".valid0"}, 32'(valid0), 32'(exp0 != 4'hF));
    check({tag, ".err0"},   32'(err0),   32'(exp0 == 4'hF));
    check({tag, ".code0"},  32'(code0),  32'(exp0));
    check({tag, ".valid1"}, 32'(valid1), 32'(exp1 != 4'hF));
    check({tag, ".err1"},   32'(err1),   32'(exp1 == 4'hF));
    check({tag, ".code1"},  32'(code1),  32'(exp1));
    @(negedge clk);
    check({tag, ".drop0"}, 32'({valid0, err0}), 32'd0);
    check({tag, ".drop1"}, 32'({valid1, err1}), 32'd0);
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    datain     = '0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.code0",  32'(code0), 32'hF);
    check("rst.code1",  32'(code1), 32'hF);
    check("rst.valid0", 32'(valid0), 32'd0);
    check("rst.err0",   32'(err0), 32'd0);
    check("rst.busy0",  32'(busy0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // "r" -> 0
    sv = nv0; se = ne0;
    send_char("r");
    check("r.busy", 32'(busy0), 32'd1);
    send_term("r", 4'd0, 4'd0);
    check("r.nvalid", 32'(nv0 - sv), 32'd1);
    check("r.nerr",   32'(ne0 - se), 32'd0);

    // "s3" -> 6 then "2" -> 8, code held in between
    sv = nv0; se = ne0;
    send_char("s"); send_char("3");
    send_term("s3", 4'd6, 4'd6);
    repeat (5) @(negedge clk);
    check("s3.hold", 32'(code0), 32'd6);
    send_char("2");
    send_term("p2", 4'd8, 4'd8);
    check("s3p2.nvalid", 32'(nv0 - sv), 32'd2);
    check("s3p2.nerr",   32'(ne0 - se), 32'd0);

    // Full-length line then overflow "s1x"
    send_char("s"); send_char("1");
    send_term("s1", 4'd4, 4'd4);
    sv = nv0; se = ne0;
    send_char("s"); send_char("1"); send_char("x");
    check("ovf.busy", 32'(busy0), 32'd1);
    send_term("ovf", 4'hF, 4'hF);
    check("ovf.nerr",   32'(ne0 - se), 32'd1);
    check("ovf.nvalid", 32'(nv0 - sv), 32'd0);

    // Timeout: "t" then silence, line dropped without a strobe
    sv = nv0; se = ne0;
    send_char("t");
    check("to.busy_before", 32'(busy0), 32'd1);
    repeat (30) @(negedge clk);
    check("to.busy_after", 32'(busy0), 32'd0);
    check("to.nstrobe",    32'(nv0 - sv + ne0 - se), 32'd0);
    check("to.code_held",  32'(code0), 32'hF);
    send_char("g");
    send_term("g", 4'd3, 4'd3);

    // Accepted character restarts the timeout: "t", 12 idle, "2", 12 idle
    send_char("t");
    repeat (12) @(negedge clk);
    send_char("2");
    repeat (12) @(negedge clk);
    check("to_clr.busy", 32'(busy0), 32'd1);
    send_term("t2", 4'd2, 4'd2);

    // Single-character player command and a non-printable character
    send_char("1");
    send_term("p1", 4'd7, 4'd7);
    send_char(7'h01);
    send_term("ctl", 4'hF, 4'hF);

    // Bare CR is an empty-line error
    send_term("empty", 4'hF, 4'hF);

    // Upper case: error without folding, "g" with folding
    send_char("G");
    send_term("G", 4'hF, 4'd3);

    // Reset mid-line, then CR alone is an empty line
    sv = nv0; se = ne0;
    send_char("s"); send_char("2");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst.code0", 32'(code0), 32'hF);
    check("mid_rst.code1", 32'(code1), 32'hF);
    check("mid_rst.busy0", 32'(busy0), 32'd0);
    check("mid_rst.busy1", 32'(busy1), 32'd0);
    check("mid_rst.strb",  32'({valid0, err0, valid1, err1}), 32'd0);
    check("mid_rst.nstrobe", 32'(nv0 - sv + ne0 - se), 32'd0);
    send_term("rst_empty", 4'hF, 4'hF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
